// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared widths, default parameters and helper functions for digit_scan_mux
package digit_scan_pkg;
    localparam int NIBBLE_W     = 4;
    localparam int MAX_DIGITS   = 8;
    localparam int MAX_VAL_W    = NIBBLE_W * MAX_DIGITS;
    localparam int DEF_DIGITS   = 4;
    localparam int DEF_SCAN_DIV = 50000;
    localparam int DEF_GUARD    = 2;

    // One-hot digit select; callers truncate to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

    // Leading-zero mask: walks down from the top digit, stops at the first
    // non-zero nibble or at a digit with its decimal point requested.
    // Digit 0 is never included.
    function automatic logic [MAX_DIGITS-1:0] lzb_mask(
        input logic [MAX_VAL_W-1:0]  value,
        input logic [MAX_DIGITS-1:0] dp,
        input int                    digits
    );
        logic [MAX_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int k = MAX_DIGITS - 1; k > 0; k--) begin
            if (k < digits) begin
                run  = run && (value[k*NIBBLE_W +: NIBBLE_W] == '0) && !dp[k];
                m[k] = run;
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/digit_scan_mux_scan_timer.sv
// scan_timer: slot counter, digit index, guard/on slot decode and frame-end detection
module scan_timer
    import digit_scan_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int GUARD    = DEF_GUARD
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [$clog2(DIGITS)-1:0] idx_o,
    output logic [$clog2(DIGITS)-1:0] next_idx_o,
    output logic                      slot_on_o,
    output logic                      slot_end_o,
    output logic                      frame_end_o
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [CW-1:0] slot_cnt_q;
    logic [IW-1:0] idx_q;
    logic [0:0]    slot_state;
    logic          last_idx;

    assign slot_end_o  = slot_cnt_q == CW'(SCAN_DIV - 1);
    assign last_idx    = idx_q == IW'(DIGITS - 1);
    assign next_idx_o  = last_idx ? '0 : idx_q + IW'(1);
    assign frame_end_o = slot_end_o && last_idx;
    assign idx_o       = idx_q;
    assign slot_on_o   = slot_state == ST_ON;

    // Guard window at the start of each slot keeps all digits dark.
    always_comb slot_state = (slot_cnt_q < CW'(GUARD)) ? ST_GUARD : ST_ON;

    // Free-running slot counter; the digit index advances on each wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            slot_cnt_q <= slot_end_o ? '0 : slot_cnt_q + CW'(1);
            if (slot_end_o) idx_q <= next_idx_o;
        end
    end
endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: multiplexed display scan with double-buffered value load.
// Optional leading-zero blanking is enabled by defining DIGIT_SCAN_LZB_EN.
module digit_scan_mux
    import digit_scan_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int GUARD    = DEF_GUARD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NIBBLE_W*DIGITS-1:0] val_in,
    input  logic [DIGITS-1:0]          dp_mask_in,
    input  logic [DIGITS-1:0]          blank_mask_in,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [NIBBLE_W-1:0]        bin_out,
    output logic                       dp_en_out,
    output logic [DIGITS-1:0]          digit_en,
    output logic                       frame_tick
);
    localparam int IW = $clog2(DIGITS);
    localparam int VW = NIBBLE_W * DIGITS;

    logic [IW-1:0]       idx, next_idx;
    logic                slot_on, slot_end, frame_end;
    logic [VW-1:0]       act_val_q, pend_val_q, src_val;
    logic [DIGITS-1:0]   act_dp_q, act_blank_q, pend_dp_q, pend_blank_q;
    logic [DIGITS-1:0]   src_dp, commit_blank;
    logic                pend_full_q, accept, commit;
    logic [NIBBLE_W-1:0] bin_q;
    logic                dp_q;

    scan_timer #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .GUARD   (GUARD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx_o      (idx),
        .next_idx_o (next_idx),
        .slot_on_o  (slot_on),
        .slot_end_o (slot_end),
        .frame_end_o(frame_end)
    );

    assign accept = load_valid && !pend_full_q;
    assign commit = frame_end && pend_full_q;

`ifdef DIGIT_SCAN_LZB_EN
    assign commit_blank = pend_blank_q |
        DIGITS'(lzb_mask(MAX_VAL_W'(pend_val_q), MAX_DIGITS'(pend_dp_q), DIGITS));
`else
    assign commit_blank = pend_blank_q;
`endif

    // On a commit edge the output registers must see the incoming value, not the outgoing one.
    assign src_val = commit ? pend_val_q : act_val_q;
    assign src_dp  = commit ? pend_dp_q : act_dp_q;

    // Pending buffer accepts one value; it moves to the active set only at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_full_q  <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
        end else begin
            if (accept) begin
                pend_val_q   <= val_in;
                pend_dp_q    <= dp_mask_in;
                pend_blank_q <= blank_mask_in;
                pend_full_q  <= 1'b1;
            end else if (commit) begin
                pend_full_q  <= 1'b0;
            end
            if (commit) begin
                act_val_q   <= pend_val_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= commit_blank;
            end
        end
    end

    // Digit data changes only at slot boundaries, while the guard window holds the selects low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            dp_q  <= 1'b0;
        end else if (slot_end) begin
            bin_q <= src_val[{next_idx, 2'b00} +: NIBBLE_W];
            dp_q  <= src_dp[next_idx];
        end
    end

    // Common-electrode select: one-hot during the on window unless the digit is blanked.
    always_comb digit_en = (slot_on && !act_blank_q[idx]) ? DIGITS'(onehot(3'(idx))) : '0;

    assign load_ready = !pend_full_q;
    assign frame_tick = frame_end;
    assign bin_out    = bin_q;
    assign dp_en_out  = dp_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: scoreboard bench for digit_scan_mux with DIGITS=4, SCAN_DIV=8, GUARD=2
module tb_digit_scan_mux;
    typedef struct {
        int         cyc;
        logic [3:0] bin;
        logic       dp;
        logic [3:0] en;
        logic       rdy;
        logic       tick;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] val_in = '0;
    logic [3:0]  dp_mask_in = '0;
    logic [3:0]  blank_mask_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  bin_out;
    logic        dp_en_out;
    logic [3:0]  digit_en;
    logic        frame_tick;

    int   cyc;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t head;

    digit_scan_mux #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .val_in       (val_in),
        .dp_mask_in   (dp_mask_in),
        .blank_mask_in(blank_mask_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .bin_out      (bin_out),
        .dp_en_out    (dp_en_out),
        .digit_en     (digit_en),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [3:0] b, input logic d, input logic [3:0] e,
                             input logic r, input logic t, input string n);
        exp_t x;
        x.cyc = c; x.bin = b; x.dp = d; x.en = e; x.rdy = r; x.tick = t; x.name = n;
        exp_q.push_back(x);
    endtask

    task automatic compare(input string n, input logic [3:0] b, input logic d, input logic [3:0] e,
                           input logic r, input logic t);
        checks++;
        if ({bin_out, dp_en_out, digit_en, load_ready, frame_tick} !== {b, d, e, r, t}) begin
            failures++;
            $display("FAIL %s cyc=%0d got bin=%h dp=%b en=%b rdy=%b tick=%b want bin=%h dp=%b en=%b rdy=%b tick=%b",
                     n, cyc, bin_out, dp_en_out, digit_en, load_ready, frame_tick, b, d, e, r, t);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard_cnt = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard_cnt++;
            if (guard_cnt > 1000) begin
                $display("FAIL wait_cyc timeout waiting for cycle %0d", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Monitor: pops expectations whose cycle has arrived and compares against the live outputs.
    always @(negedge clk) begin
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                head = exp_q.pop_front();
                if (head.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missed: now cyc=%0d want cyc=%0d", head.name, cyc, head.cyc);
                end else begin
                    compare(head.name, head.bin, head.dp, head.en, head.rdy, head.tick);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase 1: idle dark frame, load 1A3F, held second load 7C05 with blank/dp masks, then reset.
        expect_at(0,   4'h0, 0, 4'b0000, 1, 0, "reset_idle");
        expect_at(3,   4'h0, 0, 4'b0000, 1, 0, "pre_accept");
        expect_at(4,   4'h0, 0, 4'b0000, 0, 0, "pend_full");
        expect_at(10,  4'h0, 0, 4'b0000, 0, 0, "dark_before_commit");
        expect_at(31,  4'h0, 0, 4'b0000, 0, 1, "frame_end0");
        expect_at(32,  4'hF, 0, 4'b0000, 1, 0, "commit_guard");
        expect_at(33,  4'hF, 0, 4'b0000, 0, 0, "second_captured");
        expect_at(34,  4'hF, 0, 4'b0001, 0, 0, "d0_on_first");
        expect_at(39,  4'hF, 0, 4'b0001, 0, 0, "d0_on_last");
        expect_at(40,  4'h3, 0, 4'b0000, 0, 0, "d1_guard");
        expect_at(42,  4'h3, 0, 4'b0010, 0, 0, "d1_on");
        expect_at(50,  4'hA, 0, 4'b0100, 0, 0, "d2_on");
        expect_at(58,  4'h1, 0, 4'b1000, 0, 0, "d3_on");
        expect_at(63,  4'h1, 0, 4'b1000, 0, 1, "frame_end1");
        expect_at(64,  4'h5, 1, 4'b0000, 1, 0, "f2_d0_guard_dp");
        expect_at(66,  4'h5, 1, 4'b0001, 1, 0, "f2_d0_on_dp");
        expect_at(74,  4'h0, 0, 4'b0010, 1, 0, "f2_d1_on");
        expect_at(82,  4'hC, 0, 4'b0000, 1, 0, "f2_d2_blank_a");
        expect_at(87,  4'hC, 0, 4'b0000, 1, 0, "f2_d2_blank_b");
        expect_at(90,  4'h7, 0, 4'b1000, 1, 0, "f2_d3_on");
        expect_at(95,  4'h7, 0, 4'b1000, 1, 1, "frame_end2");
        expect_at(100, 4'h5, 1, 4'b0001, 1, 0, "f3_pre_accept");
        expect_at(101, 4'h5, 1, 4'b0001, 0, 0, "f3_pend_full");
        expect_at(105, 4'h0, 0, 4'b0000, 0, 0, "f3_d1_guard");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        wait_cyc(3);
        val_in = 16'h1A3F; dp_mask_in = 4'b0000; blank_mask_in = 4'b0000; load_valid = 1'b1;
        wait_cyc(4);
        load_valid = 1'b0;
        wait_cyc(20);
        val_in = 16'h7C05; dp_mask_in = 4'b0001; blank_mask_in = 4'b0100; load_valid = 1'b1;
        wait_cyc(33);
        load_valid = 1'b0;
        wait_cyc(100);
        val_in = 16'h1234; dp_mask_in = 4'b0000; blank_mask_in = 4'b0000; load_valid = 1'b1;
        wait_cyc(101);
        load_valid = 1'b0;
        wait_cyc(105);
        #2 rst = 1'b0;
        #1 compare("async_reset", 4'h0, 0, 4'b0000, 1, 0);
        repeat (2) @(posedge clk);
        // Phase 2: after reset the discarded pending value must never appear.
`ifdef DIGIT_SCAN_LZB_EN
        expect_at(10, 4'h0, 0, 4'b0000, 0, 0, "post_rst_dark");
        expect_at(34, 4'h5, 0, 4'b0001, 1, 0, "lzb5_d0");
        expect_at(42, 4'h0, 0, 4'b0000, 0, 0, "lzb5_d1_dark");
        expect_at(58, 4'h0, 0, 4'b0000, 0, 0, "lzb5_d3_dark");
        expect_at(63, 4'h0, 0, 4'b0000, 0, 1, "lzb_frame_end");
        expect_at(66, 4'h0, 0, 4'b0001, 1, 0, "lzb0_d0_lit");
        expect_at(74, 4'h0, 0, 4'b0000, 1, 0, "lzb0_d1_dark");
        expect_at(90, 4'h0, 0, 4'b0000, 1, 0, "lzb0_d3_dark");
        #2 rst = 1'b1;
        wait_cyc(2);
        val_in = 16'h0005; dp_mask_in = 4'b0000; blank_mask_in = 4'b0000; load_valid = 1'b1;
        wait_cyc(3);
        load_valid = 1'b0;
        wait_cyc(40);
        val_in = 16'h0000; load_valid = 1'b1;
        wait_cyc(41);
        load_valid = 1'b0;
        wait_cyc(96);
`else
        expect_at(0,  4'h0, 0, 4'b0000, 1, 0, "post_rst_idle");
        expect_at(10, 4'h0, 0, 4'b0000, 1, 0, "post_rst_dark");
        expect_at(31, 4'h0, 0, 4'b0000, 1, 1, "post_rst_frame_end");
        expect_at(44, 4'h0, 0, 4'b0000, 1, 0, "pending_discarded");
        expect_at(63, 4'h0, 0, 4'b0000, 1, 1, "post_rst_frame_end2");
        #2 rst = 1'b1;
        wait_cyc(64);
`endif
        repeat (2) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, first %s", exp_q.size(), exp_q[0].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
